// File: rtl/xgriscv_mem_pkg.sv
// Shared definitions for the xgriscv data memory path:
// RW_type encodings, FSM states and access legality helpers.
package xgriscv_mem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  function automatic logic is_legal_rwtype(
    input logic [2:0] t
  );
    logic ok;
    ok = 1'b0;
    unique case (t)
      RW_B, RW_H, RW_W,
      RW_BU, RW_HU: ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] t,
    input logic [1:0] off
  );
    logic half;
    half = (t == RW_H) || (t == RW_HU);
    return (half && off[0]) ||
           ((t == RW_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store byte enables and aligned store word,
// plus lane selection and sign/zero extension of load data.
module dmem_lane_fmt
  import xgriscv_mem_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        sx;

  assign shifted = rword_i >> {off_i, 3'b000};
  assign is_b    = (type_i[1:0] == 2'b00);
  assign is_h    = (type_i[1:0] == 2'b01);
  assign is_w    = (type_i[1:0] == 2'b10);
  // type bit 2 selects the unsigned variants
  assign sx      = ~type_i[2];

  always_comb begin
    be_o    = 4'b0000;
    wword_o = '0;
    rdata_o = '0;
    unique case (1'b1)
      is_b: begin
        be_o    = 4'b0001 << off_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{shifted[7] & sx}},
                   shifted[7:0]};
      end
      is_h: begin
        be_o    = off_i[1] ? 4'b1100
                           : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{shifted[15] & sx}},
                   shifted[15:0]};
      end
      is_w: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        be_o    = 4'b0000;
        wword_o = '0;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_waitstate.sv
// Data memory with valid/ready request handshake, programmable
// wait states and fault responses for the xgriscv MEM stage.
module dmem_waitstate
  import xgriscv_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES =
    (ADDR_W+1)'(DEPTH * 4);
  localparam logic [3:0] WAIT_INIT =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [31:0] mem [0:DEPTH-1];

  dmem_state_e       state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        type_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              idle;
  logic              go_resp;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [2:0]        e_type;
  logic [31:0]       e_wdata;
  logic              fault;
  logic              do_write;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       ld_data;

  assign idle = (state_q == ST_IDLE);

  // With no wait states RESP is entered on the accept edge itself,
  // so the live request is used before it reaches the latches.
  assign go_resp =
    (idle && req_valid && (WAIT_CYCLES == 0)) ||
    ((state_q == ST_WAIT) && (cnt_q == 4'd0));

  assign e_we    = idle ? req_we    : we_q;
  assign e_addr  = idle ? req_addr  : addr_q;
  assign e_type  = idle ? req_type  : type_q;
  assign e_wdata = idle ? req_wdata : wdata_q;

  assign fault =
    !is_legal_rwtype(e_type) ||
    is_misaligned(e_type, e_addr[1:0]) ||
    ({1'b0, e_addr} >= MEM_BYTES);

  assign idx      = e_addr[IDX_W+1:2];
  assign rword    = mem[idx];
  assign do_write = go_resp && e_we &&
                    !fault && !reset;

  dmem_lane_fmt u_fmt (
    .type_i  (e_type),
    .off_i   (e_addr[1:0]),
    .wdata_i (e_wdata),
    .rword_i (rword),
    .be_o    (be),
    .wword_o (wword),
    .rdata_o (ld_data)
  );

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      type_q      <= 3'b000;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      if (go_resp) begin
        state_q     <= ST_RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= fault;
        rsp_rdata_q <= (fault || e_we) ? '0
                                       : ld_data;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            type_q  <= req_type;
            wdata_q <= req_wdata;
            if (WAIT_CYCLES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = idle;
  assign busy      = !idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
